envelope_follower: RTL

- Per-channel envelope detector that sits directly upstream of the mixer.
- Takes the N_FILTERS band-pass analysis outputs of the modulator signal and full-wave rectifies each one.
- Applies a one-pole attack/release smoother per channel and publishes the envelope_channels array the mixer multiplies against the carrier bands.
- Processes one channel per clock through a shared datapath and commits all envelopes atomically, so outputs are stable for the mixer's multi-cycle read.

---
 rtl/envelope_follower_pkg.sv | 4 +
 rtl/envelope_follower.sv | 128 ++++++++++++
 2 files changed

// File: rtl/envelope_follower_pkg.sv
// Shared constants for the vocoder analysis/synthesis chain.
package envelope_follower_pkg;
  localparam int unsigned N_FILTERS = 4;
endpackage

// File: rtl/envelope_follower.sv
// Per-channel envelope detector: rectify, one-pole attack/release smoothing through a
// shared one-channel-per-clock datapath, then commit all envelopes atomically to the mixer.
module envelope_follower
  import envelope_follower_pkg::*;
#(
  parameter int unsigned N_CH = N_FILTERS
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   valid_in,
  input  logic [4:0]             attack_shift,
  input  logic [4:0]             release_shift,
  input  logic [N_CH-1:0][31:0]  band_channels,
  output logic [N_CH-1:0][31:0]  envelope_channels,
  output logic                   valid_out,
  output logic                   busy_out
);

  typedef enum logic [1:0] {IDLE, PROCESS, COMMIT} state_t;

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_CH-1:0][31:0]  cap_q, cap_d;
  logic [N_CH-1:0][31:0]  env_q, env_d;
  logic [N_CH-1:0][31:0]  out_q, out_d;
  logic [4:0]             atk_q, atk_d;
  logic [4:0]             rel_q, rel_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic [31:0] cap_sel, env_sel, x_abs, env_new;
  logic [32:0] x_w, env_w, diff_w, step_w;

  // Shared datapath; both differences are non-negative so the shifts are logical.
  always_comb begin
    cap_sel = cap_q[idx_q];
    env_sel = env_q[idx_q];
    if (cap_sel == 32'h8000_0000) begin
      x_abs = 32'h7FFF_FFFF;
    end else if (cap_sel[31]) begin
      x_abs = ~cap_sel + 32'd1;
    end else begin
      x_abs = cap_sel;
    end
    x_w   = {1'b0, x_abs};
    env_w = {1'b0, env_sel};
    if (x_w > env_w) begin
      diff_w  = x_w - env_w;
      step_w  = diff_w >> atk_q;
      env_new = 32'(env_w + step_w);
    end else begin
      diff_w  = env_w - x_w;
      step_w  = diff_w >> rel_q;
      env_new = 32'(env_w - step_w);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    env_d   = env_q;
    out_d   = out_q;
    atk_d   = atk_q;
    rel_d   = rel_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          cap_d   = band_channels;
          atk_d   = attack_shift;
          rel_d   = release_shift;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = PROCESS;
        end
      end
      PROCESS: begin
        env_d[idx_q] = env_new;
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      COMMIT: begin
        out_d   = env_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
      env_q   <= '0;
      out_q   <= '0;
      atk_q   <= '0;
      rel_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      env_q   <= env_d;
      out_q   <= out_d;
      atk_q   <= atk_d;
      rel_q   <= rel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign envelope_channels = out_q;
  assign valid_out         = valid_q;
  assign busy_out          = busy_q;

endmodule
